// File: rtl/fft_bfly_sched_if.sv
// Bus between the FFT compute-phase scheduler and the memory/butterfly datapath.
// The scheduler drives addresses and status; the datapath side drives start/hold.
interface fft_bfly_sched_if #(
    parameter int LOG2N = 4
);
    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    logic             start;
    logic             hold;
    logic             busy;
    logic             done;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] w_addr;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;
    logic             wr_en;
    logic             wb_sel;
    logic [SW-1:0]    stage;

    modport master (
        input  start, hold,
        output busy, done, rd_addr_a, rd_addr_b, w_addr,
               wr_addr_a, wr_addr_b, wr_en, wb_sel, stage
    );

    modport slave (
        output start, hold,
        input  busy, done, rd_addr_a, rd_addr_b, w_addr,
               wr_addr_a, wr_addr_b, wr_en, wb_sel, stage
    );
endinterface

// File: rtl/fft_bfly_sched.sv
// In-place radix-2 DIT FFT compute scheduler: walks LOG2N stages of N/2 butterflies,
// issues read/twiddle addresses and replays them as write-back after BF_LAT cycles.
module fft_bfly_sched #(
    parameter int LOG2N  = 4,
    parameter int BF_LAT = 1
) (
    input logic              clk,
    input logic              reset,
    fft_bfly_sched_if.master bus
);
    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [LOG2N-2:0] LAST_BFLY  = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state;
    logic [SW-1:0]    stage_q;
    logic [LOG2N-2:0] bfly_q;
    logic             busy_q;
    logic             done_q;
    logic [LOG2N-1:0] last_a_q;
    logic [LOG2N-1:0] last_b_q;
    logic [LOG2N-2:0] last_w_q;

    logic [BF_LAT-1:0] dl_valid;
    logic [LOG2N-1:0]  dl_a [BF_LAT];
    logic [LOG2N-1:0]  dl_b [BF_LAT];

    logic             issue;
    logic             pending;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    logic [LOG2N-1:0] a_c;
    logic [LOG2N-1:0] b_c;
    logic [LOG2N-2:0] w_c;

    assign issue = (state == ISSUE) && !bus.hold;

    always_comb begin
        span = LOG2N'(1) << stage_q;
        pos  = {1'b0, bfly_q} & (span - LOG2N'(1));
        grp  = {1'b0, bfly_q} >> stage_q;
        a_c  = ((grp << 1) << stage_q) | pos;
        b_c  = a_c + span;
        w_c  = pos[LOG2N-2:0] << (LAST_STAGE - stage_q);
    end

    // Entries still ahead of the tail; the tail itself is being written this cycle.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < BF_LAT - 1; i++) pending = pending | dl_valid[i];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the block order cannot change behaviour.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the address fields are cleared too, not just the valid bits,
            // because the tail drives the write-address outputs directly.
            for (int i = 0; i < BF_LAT; i++) begin
                dl_valid[i] <= 1'b0;
                dl_a[i]     <= '0;
                dl_b[i]     <= '0;
            end
        end else begin
            dl_valid[0] <= issue;
            dl_a[0]     <= a_c;
            dl_b[0]     <= b_c;
            for (int i = 1; i < BF_LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_a[i]     <= dl_a[i-1];
                dl_b[i]     <= dl_b[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            stage_q  <= '0;
            bfly_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            last_a_q <= '0;
            last_b_q <= '0;
            last_w_q <= '0;
        end else begin
            if (issue) begin
                last_a_q <= a_c;
                last_b_q <= b_c;
                last_w_q <= w_c;
            end
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state   <= ISSUE;
                        stage_q <= '0;
                        bfly_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!bus.hold) begin
                        if (bfly_q == LAST_BFLY) state <= DRAIN;
                        bfly_q <= bfly_q + (LOG2N-1)'(1);
                    end
                end
                DRAIN: begin
                    if (!pending) begin
                        if (stage_q == LAST_STAGE) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ISSUE;
                            stage_q <= stage_q + SW'(1);
                            bfly_q  <= '0;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read addresses show the issuing butterfly, otherwise the last one issued.
    assign bus.rd_addr_a = issue ? a_c : last_a_q;
    assign bus.rd_addr_b = issue ? b_c : last_b_q;
    assign bus.w_addr    = issue ? w_c : last_w_q;
    assign bus.wr_en     = dl_valid[BF_LAT-1];
    assign bus.wb_sel    = dl_valid[BF_LAT-1];
    assign bus.wr_addr_a = dl_a[BF_LAT-1];
    assign bus.wr_addr_b = dl_b[BF_LAT-1];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.stage     = stage_q;
endmodule

// File: tb/tb_fft_bfly_sched.sv
// Scoreboard bench for fft_bfly_sched: expected reads/writes are queued at start
// with their due cycles and popped as the scheduler produces them.
module tb_fft_bfly_sched;
    localparam int LOG2N  = 4;
    localparam int N      = 16;
    localparam int HALF   = 8;
    localparam int BF_LAT = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fft_bfly_sched_if #(.LOG2N(LOG2N)) bus ();
    fft_bfly_sched_if #(.LOG2N(LOG2N)) bus3 ();

    fft_bfly_sched #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
    fft_bfly_sched #(.LOG2N(LOG2N), .BF_LAT(3))      dut3 (.clk(clk), .reset(reset), .bus(bus3));

    typedef struct {
        int s;
        int a;
        int b;
        int w;
        int cyc;
    } exp_t;

    exp_t rq[$];
    exp_t wq[$];
    int   wq3[$];
    exp_t er;
    exp_t ew;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int t0 = 0;
    int t3 = 0;
    bit active = 1'b0;
    int hold_lo = 0;
    int hold_len = 0;
    int exp_done = 0;
    int busy_cnt, done_cnt, wr_cnt;
    int last_rd_a, last_rd_b;
    bit done_seen;
    int busy3 = 0, wr3 = 0, done3 = 0;

    int mem [N];
    int xp, yp;
    bit mem_init = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rel();
        return cyc - t0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory plus a one-cycle add/subtract butterfly; twiddles are ignored.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < N; i++) mem[i] <= 1;
        end else if (bus.wr_en) begin
            mem[bus.wr_addr_a] <= xp;
            mem[bus.wr_addr_b] <= yp;
        end
        xp <= mem[bus.rd_addr_a] + mem[bus.rd_addr_b];
        yp <= mem[bus.rd_addr_a] - mem[bus.rd_addr_b];
    end

    always @(negedge clk) begin
        if (active) begin
            if (rq.size() > 0 && rq[0].cyc == rel()) begin
                er = rq.pop_front();
                check("rd_a", int'(bus.rd_addr_a), er.a);
                check("rd_b", int'(bus.rd_addr_b), er.b);
                check("w_addr", int'(bus.w_addr), er.w);
                check("stage", int'(bus.stage), er.s);
                last_rd_a = er.a;
                last_rd_b = er.b;
            end else if (hold_len > 0 && rel() >= hold_lo && rel() < hold_lo + hold_len) begin
                check("hold_rd_a", int'(bus.rd_addr_a), last_rd_a);
                check("hold_rd_b", int'(bus.rd_addr_b), last_rd_b);
            end
            if (bus.wr_en) begin
                wr_cnt++;
                if (wq.size() == 0) begin
                    check("wr_extra", int'(bus.wr_en), 0);
                end else begin
                    ew = wq.pop_front();
                    check("wr_a", int'(bus.wr_addr_a), ew.a);
                    check("wr_b", int'(bus.wr_addr_b), ew.b);
                    check("wr_cycle", rel(), ew.cyc);
                    check("wb_sel", int'(bus.wb_sel), 1);
                end
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_seen = 1'b1;
                check("done_cycle", rel(), exp_done);
                check("done_busy", int'(bus.busy), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (bus3.busy) busy3++;
        if (bus3.done) begin
            done3++;
            check("done3_cycle", cyc - t3, 45);
        end
        if (bus3.wr_en) begin
            wr3++;
            if (wq3.size() == 0) check("wr3_extra", int'(bus3.wr_en), 0);
            else check("wr3_addr", int'(bus3.wr_addr_a) * N + int'(bus3.wr_addr_b), wq3.pop_front());
        end
    end

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},  int'(bus.busy), 0);
        check({tag, "_done"},  int'(bus.done), 0);
        check({tag, "_rd_a"},  int'(bus.rd_addr_a), 0);
        check({tag, "_rd_b"},  int'(bus.rd_addr_b), 0);
        check({tag, "_w"},     int'(bus.w_addr), 0);
        check({tag, "_wr_a"},  int'(bus.wr_addr_a), 0);
        check({tag, "_wr_b"},  int'(bus.wr_addr_b), 0);
        check({tag, "_wr_en"}, int'(bus.wr_en), 0);
        check({tag, "_wbsel"}, int'(bus.wb_sel), 0);
        check({tag, "_stage"}, int'(bus.stage), 0);
    endtask

    // Expected schedule: stage s, butterfly b reads at 1 + s*(HALF+BF_LAT) + b,
    // shifted by the hold length once the hold window has started.
    task automatic run(input int h_lo, input int h_len, input bit poke, input int abort_at);
        exp_t e;
        int exp_busy;
        rq.delete();
        wq.delete();
        for (int s = 0; s < LOG2N; s++) begin
            for (int b = 0; b < HALF; b++) begin
                int span;
                span  = 1 << s;
                e.s   = s;
                e.a   = (b / span) * (2 * span) + (b % span);
                e.b   = e.a + span;
                e.w   = (b % span) * (HALF >> s);
                e.cyc = 1 + s * (HALF + BF_LAT) + b;
                if (h_len > 0 && e.cyc >= h_lo) e.cyc += h_len;
                rq.push_back(e);
                e.cyc += BF_LAT;
                wq.push_back(e);
            end
        end
        hold_lo   = h_lo;
        hold_len  = h_len;
        exp_busy  = LOG2N * (HALF + BF_LAT) + h_len;
        exp_done  = exp_busy + 1;
        busy_cnt  = 0;
        done_cnt  = 0;
        wr_cnt    = 0;
        done_seen = 1'b0;
        last_rd_a = -1;
        last_rd_b = -1;

        bus.start = 1'b1;
        t0 = cyc;
        active = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus3.start = 1'b0;

        while (!done_seen && rel() < exp_done + 50) begin
            if (abort_at > 0 && rel() == abort_at) begin
                int wr_after, done_after;
                active = 1'b0;
                reset  = 1'b0;
                tick();
                tick();
                check_idle_zero("abort");
                reset = 1'b1;
                wr_after = 0;
                done_after = 0;
                for (int k = 0; k < 20; k++) begin
                    tick();
                    if (bus.wr_en) wr_after++;
                    if (bus.done) done_after++;
                end
                check("abort_wr", wr_after, 0);
                check("abort_done", done_after, 0);
                return;
            end
            bus.hold  = (h_len > 0 && rel() >= h_lo && rel() < h_lo + h_len);
            bus.start = poke && (rel() == 5 || rel() == exp_done);
            tick();
        end
        bus.hold  = 1'b0;
        bus.start = 1'b0;
        active    = 1'b0;
        check("done_seen", int'(done_seen), 1);
        check("done_count", done_cnt, 1);
        check("busy_cycles", busy_cnt, exp_busy);
        check("writes", wr_cnt, HALF * LOG2N);
        check("rd_left", rq.size(), 0);
        check("wr_left", wq.size(), 0);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.hold   = 1'b0;
        bus3.start = 1'b0;
        bus3.hold  = 1'b0;

        reset = 1'b0;
        repeat (2) tick();
        check_idle_zero("rst");
        reset = 1'b1;
        tick();

        // Plain run with start pokes in ISSUE and DONE; BF_LAT=3 instance runs alongside.
        for (int s = 0; s < LOG2N; s++)
            for (int b = 0; b < HALF; b++) begin
                int span, a;
                span = 1 << s;
                a = (b / span) * (2 * span) + (b % span);
                wq3.push_back(a * N + a + span);
            end
        bus3.start = 1'b1;
        t3 = cyc;
        run(0, 0, 1'b1, 0);

        // Starts in the IDLE cycle right after DONE; hold for 3 cycles in stage 1.
        run(12, 3, 1'b0, 0);

        // Reset in the middle of stage 2.
        run(0, 0, 1'b0, 25);

        mem_init = 1'b1;
        tick();
        mem_init = 1'b0;
        run(0, 0, 1'b0, 0);
        for (int i = 0; i < N; i++)
            check($sformatf("bin%0d", i), mem[i], (i == 0) ? N : 0);

        check("busy3_cycles", busy3, 44);
        check("writes3", wr3, HALF * LOG2N);
        check("done3_count", done3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
